// File: rtl/mem_request_responder.sv
// Avalon-MM master that runs one read or write per request and reports completion on memDone.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_request_responder #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        modeInput,
  input  logic [ADDR_W-1:0] memoryAddress,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              memDone,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              memError
);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE_HOLD
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog_q;
  logic            err_q;
  logic            busy;

  assign busy = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_WR_REQ);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      done_q  <= 1'b1;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (modeInput == MODE_RD) begin
            addr_q  <= memoryAddress;
            rd_q    <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_RD_REQ;
          end else if (modeInput == MODE_WR) begin
            addr_q  <= memoryAddress;
            wdata_q <= write_data;
            wr_q    <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_WR_REQ;
          end
        end
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            rd_q    <= 1'b0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            rdata_q <= avm_readdata;
            done_q  <= 1'b1;
            state_q <= S_DONE_HOLD;
          end
        end
        S_WR_REQ: begin
          if (!avm_waitrequest) begin
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE_HOLD;
          end
        end
        S_DONE_HOLD: begin
          // Wait for the mode to return to none so a held level cannot retrigger.
          if (modeInput == MODE_NONE) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides normal progress.
      if (state_q == S_IDLE) begin
        wdog_q <= '0;
        if ((modeInput == MODE_RD) || (modeInput == MODE_WR)) err_q <= 1'b0;
      end else if (busy) begin
        if (wdog_q == WD_LAST) begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          if (state_q != S_WR_REQ) rdata_q <= DATA_W'(16'hDEAD);
          state_q <= S_DONE_HOLD;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
      end
`endif
    end
  end

  assign read_data     = rdata_q;
  assign memDone       = done_q;
  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;

`ifdef MEM_TIMEOUT_EN
  assign memError = err_q;
`else
  assign memError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_responder.sv
// Directed plus randomized bench for mem_request_responder; the bench plays the Avalon slave.
module tb_mem_request_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  modeInput;
  logic [24:0] memoryAddress;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        memDone;
  logic [24:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        memError;

  int checks   = 0;
  int failures = 0;

  int n_rd_acc = 0, n_wr_acc = 0, n_both = 0;
  int exp_rd = 0, exp_wr = 0;
  logic [15:0] exp_rdata = 16'h0;

  always #5 clk = ~clk;

  mem_request_responder #(
    .ADDR_W(25), .DATA_W(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .modeInput(modeInput),
    .memoryAddress(memoryAddress), .write_data(write_data),
    .read_data(read_data), .memDone(memDone),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .memError(memError)
  );

  // Bus monitor: counts accepted transfers as the slave sees them.
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) n_rd_acc++;
    if (avm_write && !avm_waitrequest) n_wr_acc++;
    if (avm_read && avm_write) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_hold(input int hold);
    for (int i = 0; i < hold; i++) begin
      modeInput = 2'($urandom_range(1, 3));
      @(negedge clk);
      chk("hold_done", memDone, 1);
      chk("hold_rd", avm_read, 0);
      chk("hold_wr", avm_write, 0);
    end
    modeInput = 2'b00;
    @(negedge clk);
    chk("back_idle_done", memDone, 1);
  endtask

  task automatic do_read(input logic [24:0] a, input int waits, input int dly,
                         input logic [15:0] d, input int hold);
    modeInput = 2'b01; memoryAddress = a; avm_waitrequest = 1'($urandom);
    @(negedge clk);
    memoryAddress = 25'($urandom); write_data = 16'($urandom);
    chk("rd_strobe", avm_read, 1);
    chk("rd_addr", avm_address, a);
    chk("rd_busy", memDone, 0);
    chk("rd_nowr", avm_write, 0);
    for (int i = 0; i < waits; i++) begin
      avm_waitrequest = 1'b1;
      avm_readdatavalid = 1'($urandom); avm_readdata = 16'($urandom);
      @(negedge clk);
      chk("rd_stall_strobe", avm_read, 1);
      chk("rd_stall_addr", avm_address, a);
    end
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'($urandom); avm_readdata = 16'($urandom);
    @(negedge clk);
    avm_waitrequest = 1'($urandom); avm_readdatavalid = 1'b0;
    chk("rd_strobe_drop", avm_read, 0);
    chk("rd_still_busy", memDone, 0);
    chk("rd_old_data", read_data, exp_rdata);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("rd_wait_busy", memDone, 0);
    end
    avm_readdata = d; avm_readdatavalid = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b0; avm_readdata = 16'($urandom);
    exp_rdata = d; exp_rd++;
    chk("rd_done", memDone, 1);
    chk("rd_data", read_data, exp_rdata);
    finish_hold(hold);
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int waits,
                          input int hold);
    modeInput = 2'b10; memoryAddress = a; write_data = d; avm_waitrequest = 1'($urandom);
    @(negedge clk);
    memoryAddress = 25'($urandom); write_data = 16'($urandom);
    chk("wr_strobe", avm_write, 1);
    chk("wr_addr", avm_address, a);
    chk("wr_data", avm_writedata, d);
    chk("wr_busy", memDone, 0);
    chk("wr_nord", avm_read, 0);
    for (int i = 0; i < waits; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("wr_stall_strobe", avm_write, 1);
      chk("wr_stall_addr", avm_address, a);
      chk("wr_stall_data", avm_writedata, d);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'($urandom);
    exp_wr++;
    chk("wr_strobe_drop", avm_write, 0);
    chk("wr_done", memDone, 1);
    chk("wr_rdata_kept", read_data, exp_rdata);
    finish_hold(hold);
  endtask

  task automatic idle_step(input logic [1:0] m);
    modeInput = m;
    avm_readdatavalid = 1'($urandom); avm_readdata = 16'($urandom);
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    chk("idle_done", memDone, 1);
    chk("idle_rd", avm_read, 0);
    chk("idle_wr", avm_write, 0);
    chk("idle_rdata", read_data, exp_rdata);
  endtask

  initial begin
    reset_n = 1'b0; modeInput = 2'b00; memoryAddress = '0; write_data = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    @(negedge clk);
    chk("rst_done", memDone, 1);
    chk("rst_rdata", read_data, 0);
    chk("rst_rd", avm_read, 0);
    chk("rst_wr", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_err", memError, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_read(25'h1FFFFFF, 2, 2, 16'hAAAA, 0);
    do_write(25'h00FF00, 16'hCCCC, 4, 0);
    do_write(25'h0000001, 16'h1234, 0, 0);
    do_read(25'h0000000, 0, 0, 16'h5A5A, 20);
    do_write(25'h1555555, 16'hFFFF, 1, 3);
    idle_step(2'b11); idle_step(2'b11); idle_step(2'b00); idle_step(2'b11);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: idle_step(2'b00);
        1: do_read(25'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   16'($urandom), $urandom_range(0, 3));
        2: do_write(25'($urandom), 16'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3));
        default: idle_step(2'b11);
      endcase
    end

    // Asynchronous reset while a read is stalled.
    do_read(25'h0ABCDEF, 0, 1, 16'hBEEF, 0);
    modeInput = 2'b01; memoryAddress = 25'h0123456; avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("pre_rst_strobe", avm_read, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", avm_read, 0);
    chk("arst_done", memDone, 1);
    chk("arst_rdata", read_data, 0);
    chk("arst_addr", avm_address, 0);
    exp_rdata = 16'h0;
    modeInput = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    do_write(25'h0000F0F, 16'h0F0F, 0, 0);

`ifdef MEM_TIMEOUT_EN
    modeInput = 2'b01; memoryAddress = 25'h0000042; avm_waitrequest = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_busy", memDone, 0);
      chk("to_noerr", memError, 0);
    end
    @(negedge clk);
    chk("to_err", memError, 1);
    chk("to_dead", read_data, 16'hDEAD);
    chk("to_done", memDone, 1);
    chk("to_rd", avm_read, 0);
    exp_rdata = 16'hDEAD;
    avm_waitrequest = 1'b0;
    finish_hold(2);
    do_read(25'h0000043, 0, 0, 16'h7777, 0);
    chk("to_err_clear", memError, 0);
`else
    chk("noto_err", memError, 0);
`endif

    chk("rd_accepts", n_rd_acc, exp_rd);
    chk("wr_accepts", n_wr_acc, exp_wr);
    chk("rd_wr_overlap", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
